rob_gen2: RTL and testbench

ROB_GEN2 -- requirements
Module: rob_gen2

---
 rtl/rob_gen2.sv | 212 +++++++++++++++++++++
 tb/tb_rob_gen2.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_gen2.sv
// rob_gen2: circular reorder buffer with multi-channel result broadcast,
// combinational operand lookup, dual in-order retire and branch flush.
module rob_gen2 #(
    parameter int ROB_BIT     = 3,
    parameter int NCDB        = 2,
    parameter int DUAL_COMMIT = 1
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    input  logic                    rdy_in,
    input  logic                    issue_valid,
    input  logic [6:0]              issue_op_type,
    input  logic [4:0]              issue_rd,
    input  logic [31:0]             issue_pc,
    input  logic signed [31:0]      issue_imm,
    input  logic                    issue_br_pred,
    input  logic                    issue_is_c,
    output logic [ROB_BIT-1:0]      issue_entry,
    output logic                    rob_full,
    output logic                    rob_empty,
    output logic [ROB_BIT:0]        rob_count,
    input  logic [NCDB-1:0]         cdb_valid,
    input  logic [NCDB*ROB_BIT-1:0] cdb_entry,
    input  logic [NCDB*32-1:0]      cdb_value,
    input  logic [ROB_BIT-1:0]      qry_entry1,
    input  logic [ROB_BIT-1:0]      qry_entry2,
    output logic                    qry_ready1,
    output logic                    qry_ready2,
    output logic [31:0]             qry_value1,
    output logic [31:0]             qry_value2,
    output logic [1:0]              ret_valid,
    output logic [1:0]              ret_wr,
    output logic [9:0]              ret_rd,
    output logic [2*ROB_BIT-1:0]    ret_entry,
    output logic [63:0]             ret_value,
    output logic                    flush,
    output logic [31:0]             flush_pc
);
    localparam int DEPTH = 1 << ROB_BIT;
    localparam int CW    = ROB_BIT + 1;

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_ST    = 7'b0100011;

    // Entry control (reset) and payload (no reset) state.
    logic [DEPTH-1:0]   busy, prep;
    logic [6:0]         op_q   [DEPTH];
    logic [4:0]         rd_q   [DEPTH];
    logic [31:0]        pc_q   [DEPTH];
    logic signed [31:0] imm_q  [DEPTH];
    logic [31:0]        val_q  [DEPTH];
    logic [DEPTH-1:0]   pred_q, isc_q;
    logic [ROB_BIT-1:0] head, tail;
    logic [ROB_BIT:0]   count;

    logic [ROB_BIT-1:0] h0, h1;
    logic               br_mispred, ret0, ret1, do_issue;
    logic [DEPTH-1:0]   cdb_we;
    logic [31:0]        cdb_val [DEPTH];
    logic [32:0]        iss_res;

    function automatic logic [31:0] link_pc(input logic [31:0] pc, input logic is_c);
        return pc + (is_c ? 32'd2 : 32'd4);
    endfunction

    function automatic logic [31:0] target_pc(input logic [31:0] pc, input logic signed [31:0] imm);
        return $unsigned($signed(pc) + imm);
    endfunction

    // {prepared, value} for ops whose result is known at issue time.
    function automatic logic [32:0] issue_result(input logic [6:0] op, input logic [31:0] pc,
                                                 input logic signed [31:0] imm, input logic is_c);
        case (op)
            OP_LUI:          return {1'b1, $unsigned(imm)};
            OP_AUIPC:        return {1'b1, target_pc(pc, imm)};
            OP_JAL, OP_JALR: return {1'b1, link_pc(pc, is_c)};
            default:         return 33'd0;
        endcase
    endfunction

    function automatic logic writes_rf(input logic [6:0] op, input logic [4:0] rd);
        return (op != OP_BR) && (op != OP_ST) && (rd != 5'd0);
    endfunction

    assign h0          = head;
    assign h1          = head + 1'b1;
    assign issue_entry = tail;
    assign rob_count   = count;
    assign rob_full    = (count == CW'(DEPTH));
    assign rob_empty   = (count == '0);
    assign do_issue    = rdy_in && issue_valid && !rob_full && !flush;
    assign iss_res     = issue_result(issue_op_type, issue_pc, issue_imm, issue_is_c);

    // Head-of-buffer decisions: mispredict flush and the two retire slots.
    always_comb begin
        br_mispred = busy[h0] && prep[h0] && (op_q[h0] == OP_BR) && (val_q[h0][0] != pred_q[h0]);
        flush      = rdy_in && br_mispred;
        flush_pc   = '0;
        if (flush)
            flush_pc = val_q[h0][0] ? target_pc(pc_q[h0], imm_q[h0]) : link_pc(pc_q[h0], isc_q[h0]);
        ret0 = rdy_in && busy[h0] && prep[h0] && !br_mispred;
        ret1 = (DUAL_COMMIT != 0) && ret0 && busy[h1] && prep[h1] && (op_q[h0] != OP_BR);
    end

    // Retire outputs, zeroed on idle slots.
    always_comb begin
        ret_valid = {ret1, ret0};
        ret_wr    = {ret1 && writes_rf(op_q[h1], rd_q[h1]), ret0 && writes_rf(op_q[h0], rd_q[h0])};
        ret_rd    = {ret1 ? rd_q[h1] : 5'd0, ret0 ? rd_q[h0] : 5'd0};
        ret_entry = {ret1 ? h1 : '0, ret0 ? h0 : '0};
        ret_value = {ret1 ? val_q[h1] : 32'd0, ret0 ? val_q[h0] : 32'd0};
    end

    // Per-entry result capture; descending scan lets the lowest channel win.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            cdb_we[i]  = 1'b0;
            cdb_val[i] = '0;
            for (int c = NCDB - 1; c >= 0; c--) begin
                if (cdb_valid[c] && cdb_entry[c*ROB_BIT +: ROB_BIT] == ROB_BIT'(i)) begin
                    cdb_we[i]  = 1'b1;
                    cdb_val[i] = cdb_value[c*32 +: 32];
                end
            end
            cdb_we[i] = cdb_we[i] && busy[i] && !prep[i];
        end
    end

    // Operand lookup: stored value first, else lowest-index live broadcast.
    always_comb begin
        qry_ready1 = 1'b0;
        qry_value1 = '0;
        qry_ready2 = 1'b0;
        qry_value2 = '0;
        for (int c = NCDB - 1; c >= 0; c--) begin
            if (cdb_valid[c] && cdb_entry[c*ROB_BIT +: ROB_BIT] == qry_entry1) begin
                qry_ready1 = 1'b1;
                qry_value1 = cdb_value[c*32 +: 32];
            end
            if (cdb_valid[c] && cdb_entry[c*ROB_BIT +: ROB_BIT] == qry_entry2) begin
                qry_ready2 = 1'b1;
                qry_value2 = cdb_value[c*32 +: 32];
            end
        end
        if (prep[qry_entry1]) begin
            qry_ready1 = 1'b1;
            qry_value1 = val_q[qry_entry1];
        end
        if (prep[qry_entry2]) begin
            qry_ready2 = 1'b1;
            qry_value2 = val_q[qry_entry2];
        end
    end

    // Control state: busy/prepared flags, pointers and occupancy.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            busy  <= '0;
            prep  <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (rdy_in) begin
            if (flush) begin
                busy  <= '0;
                prep  <= '0;
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                for (int i = 0; i < DEPTH; i++)
                    if (cdb_we[i]) prep[i] <= 1'b1;
                if (ret0) begin
                    busy[h0] <= 1'b0;
                    prep[h0] <= 1'b0;
                end
                if (ret1) begin
                    busy[h1] <= 1'b0;
                    prep[h1] <= 1'b0;
                end
                if (do_issue) begin
                    busy[tail] <= 1'b1;
                    prep[tail] <= iss_res[32];
                end
                head  <= head + ROB_BIT'(ret0) + ROB_BIT'(ret1);
                tail  <= tail + ROB_BIT'(do_issue);
                count <= count + CW'(do_issue) - CW'(ret0) - CW'(ret1);
            end
        end
    end

    // Payload storage: issue fields and captured results.
    always_ff @(posedge clk_in) begin
        if (rdy_in && !flush) begin
            for (int i = 0; i < DEPTH; i++)
                if (cdb_we[i]) val_q[i] <= cdb_val[i];
            if (do_issue) begin
                op_q[tail]   <= issue_op_type;
                rd_q[tail]   <= issue_rd;
                pc_q[tail]   <= issue_pc;
                imm_q[tail]  <= issue_imm;
                pred_q[tail] <= issue_br_pred;
                isc_q[tail]  <= issue_is_c;
                val_q[tail]  <= iss_res[31:0];
            end
        end
    end
endmodule

// File: tb/tb_rob_gen2.sv
// Directed testbench for rob_gen2 (ROB_BIT=3, NCDB=2, DUAL_COMMIT=1).
module tb_rob_gen2;
    localparam logic [6:0] ADD = 7'b0110011;
    localparam logic [6:0] LUI = 7'b0110111;
    localparam logic [6:0] JAL = 7'b1101111;
    localparam logic [6:0] BEQ = 7'b1100011;

    logic        clk_in = 1'b0;
    logic        rst_n_in, rdy_in, issue_valid, issue_br_pred, issue_is_c;
    logic [6:0]  issue_op_type;
    logic [4:0]  issue_rd;
    logic [31:0] issue_pc, issue_imm;
    logic [2:0]  issue_entry;
    logic        rob_full, rob_empty;
    logic [3:0]  rob_count;
    logic [1:0]  cdb_valid;
    logic [5:0]  cdb_entry;
    logic [63:0] cdb_value;
    logic [2:0]  qry_entry1, qry_entry2;
    logic        qry_ready1, qry_ready2;
    logic [31:0] qry_value1, qry_value2;
    logic [1:0]  ret_valid, ret_wr;
    logic [9:0]  ret_rd;
    logic [5:0]  ret_entry;
    logic [63:0] ret_value;
    logic        flush;
    logic [31:0] flush_pc;

    int n_cmp = 0;
    int n_bad = 0;

    rob_gen2 #(.ROB_BIT(3), .NCDB(2), .DUAL_COMMIT(1)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
        .issue_valid(issue_valid), .issue_op_type(issue_op_type), .issue_rd(issue_rd),
        .issue_pc(issue_pc), .issue_imm(issue_imm), .issue_br_pred(issue_br_pred),
        .issue_is_c(issue_is_c), .issue_entry(issue_entry), .rob_full(rob_full),
        .rob_empty(rob_empty), .rob_count(rob_count), .cdb_valid(cdb_valid),
        .cdb_entry(cdb_entry), .cdb_value(cdb_value), .qry_entry1(qry_entry1),
        .qry_entry2(qry_entry2), .qry_ready1(qry_ready1), .qry_ready2(qry_ready2),
        .qry_value1(qry_value1), .qry_value2(qry_value2), .ret_valid(ret_valid),
        .ret_wr(ret_wr), .ret_rd(ret_rd), .ret_entry(ret_entry), .ret_value(ret_value),
        .flush(flush), .flush_pc(flush_pc)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle;
        issue_valid = 0; issue_op_type = 0; issue_rd = 0; issue_pc = 0; issue_imm = 0;
        issue_br_pred = 0; issue_is_c = 0; cdb_valid = 0; cdb_entry = 0; cdb_value = 0;
    endtask

    task automatic iss(input logic [6:0] op, input logic [4:0] rd, input logic [31:0] pc,
                       input logic [31:0] imm, input logic pred, input logic isc);
        issue_valid = 1; issue_op_type = op; issue_rd = rd; issue_pc = pc; issue_imm = imm;
        issue_br_pred = pred; issue_is_c = isc;
    endtask

    task automatic do_reset;
        rst_n_in = 0; rdy_in = 1; qry_entry1 = 0; qry_entry2 = 0;
        idle();
        tick(); tick();
        rst_n_in = 1;
        #1;
    endtask

    task automatic test_reset;
        rst_n_in = 0; rdy_in = 1; qry_entry1 = 0; qry_entry2 = 0;
        idle();
        #2;
        n_cmp++; if (rob_empty !== 1'b1) begin n_bad++; $display("FAIL reset_empty got %b want 1", rob_empty); end
        n_cmp++; if (rob_full !== 1'b0) begin n_bad++; $display("FAIL reset_full got %b want 0", rob_full); end
        n_cmp++; if (rob_count !== 4'd0) begin n_bad++; $display("FAIL reset_count got %0d want 0", rob_count); end
        n_cmp++; if (ret_valid !== 2'b00 || flush !== 1'b0 || flush_pc !== 32'd0) begin n_bad++; $display("FAIL reset_outs got rv=%b fl=%b fpc=%h want 0", ret_valid, flush, flush_pc); end
        tick(); tick();
        rst_n_in = 1;
        #1;
        iss(ADD, 5'd1, 32'h0, 32'h0, 0, 0);
        #1;
        n_cmp++; if (issue_entry !== 3'd0) begin n_bad++; $display("FAIL first_issue_entry got %0d want 0", issue_entry); end
        tick(); idle(); #1;
        n_cmp++; if (rob_count !== 4'd1) begin n_bad++; $display("FAIL first_issue_count got %0d want 1", rob_count); end
    endtask

    task automatic test_full;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            iss(ADD, 5'(i + 1), 32'(4 * i), 32'h0, 0, 0);
            #1;
            n_cmp++; if (issue_entry !== 3'(i) || rob_count !== 4'(i)) begin n_bad++; $display("FAIL fill_%0d got entry=%0d count=%0d want %0d/%0d", i, issue_entry, rob_count, i, i); end
            tick();
        end
        idle(); #1;
        n_cmp++; if (rob_full !== 1'b1 || rob_count !== 4'd8 || rob_empty !== 1'b0) begin n_bad++; $display("FAIL full_state got full=%b count=%0d empty=%b want 1/8/0", rob_full, rob_count, rob_empty); end
        n_cmp++; if (ret_valid !== 2'b00) begin n_bad++; $display("FAIL full_noretire got %b want 00", ret_valid); end
        iss(ADD, 5'd9, 32'h40, 32'h0, 0, 0);
        tick(); idle(); #1;
        n_cmp++; if (rob_count !== 4'd8 || issue_entry !== 3'd0 || rob_full !== 1'b1) begin n_bad++; $display("FAIL ninth_issue got count=%0d tail=%0d full=%b want 8/0/1", rob_count, issue_entry, rob_full); end
    endtask

    task automatic test_cdb_collision;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            iss(ADD, 5'(i + 1), 32'(4 * i), 32'h0, 0, 0);
            tick();
        end
        idle();
        cdb_valid = 2'b11; cdb_entry = {3'd3, 3'd3}; cdb_value = {32'd9, 32'd5};
        qry_entry1 = 3'd3; qry_entry2 = 3'd0;
        #1;
        n_cmp++; if (qry_ready1 !== 1'b1 || qry_value1 !== 32'd5) begin n_bad++; $display("FAIL collide_fwd got rdy=%b val=%0d want 1/5", qry_ready1, qry_value1); end
        n_cmp++; if (qry_ready2 !== 1'b0 || qry_value2 !== 32'd0) begin n_bad++; $display("FAIL notready_qry got rdy=%b val=%0d want 0/0", qry_ready2, qry_value2); end
        tick();
        cdb_valid = 2'b10; cdb_entry = {3'd3, 3'd0}; cdb_value = {32'd7, 32'd0};
        #1;
        n_cmp++; if (qry_ready1 !== 1'b1 || qry_value1 !== 32'd5) begin n_bad++; $display("FAIL stored_over_cdb got rdy=%b val=%0d want 1/5", qry_ready1, qry_value1); end
        tick();
        cdb_valid = 2'b10; cdb_entry = {3'd2, 3'd0}; cdb_value = {32'h22, 32'd0};
        qry_entry2 = 3'd2;
        #1;
        n_cmp++; if (qry_ready2 !== 1'b1 || qry_value2 !== 32'h22) begin n_bad++; $display("FAIL ch1_fwd got rdy=%b val=%h want 1/22", qry_ready2, qry_value2); end
        tick(); idle(); #1;
        n_cmp++; if (qry_value1 !== 32'd5 || qry_value2 !== 32'h22 || qry_ready2 !== 1'b1) begin n_bad++; $display("FAIL stored_vals got %0d/%h want 5/22", qry_value1, qry_value2); end
        n_cmp++; if (ret_valid !== 2'b00 || rob_count !== 4'd4) begin n_bad++; $display("FAIL head_blocked got rv=%b count=%0d want 00/4", ret_valid, rob_count); end
        qry_entry1 = 0; qry_entry2 = 0;
    endtask

    task automatic test_dual_retire;
        do_reset();
        iss(ADD, 5'd3, 32'h0, 32'h0, 0, 0); tick();
        iss(ADD, 5'd0, 32'h4, 32'h0, 0, 0); tick();
        iss(LUI, 5'd5, 32'hFC, 32'h12345000, 0, 0); tick();
        iss(JAL, 5'd1, 32'h100, 32'h40, 0, 1);
        cdb_valid = 2'b11; cdb_entry = {3'd1, 3'd0}; cdb_value = {32'hBB, 32'hAA};
        #1;
        n_cmp++; if (ret_valid !== 2'b00) begin n_bad++; $display("FAIL pre_result_retire got %b want 00", ret_valid); end
        tick(); idle(); #1;
        n_cmp++; if (ret_valid !== 2'b11 || ret_entry !== 6'b001_000) begin n_bad++; $display("FAIL dual1 got rv=%b ent=%b want 11/001000", ret_valid, ret_entry); end
        n_cmp++; if (ret_value !== {32'hBB, 32'hAA} || ret_rd !== {5'd0, 5'd3} || ret_wr !== 2'b01) begin n_bad++; $display("FAIL dual1_data got val=%h rd=%h wr=%b want bb/aa rd0/3 01", ret_value, ret_rd, ret_wr); end
        n_cmp++; if (rob_count !== 4'd4) begin n_bad++; $display("FAIL dual1_count got %0d want 4", rob_count); end
        tick(); #1;
        n_cmp++; if (ret_valid !== 2'b11 || ret_entry !== 6'b011_010) begin n_bad++; $display("FAIL lui_jal got rv=%b ent=%b want 11/011010", ret_valid, ret_entry); end
        n_cmp++; if (ret_value !== {32'h102, 32'h12345000}) begin n_bad++; $display("FAIL lui_jal_val got %h want 00000102_12345000", ret_value); end
        n_cmp++; if (ret_rd !== {5'd1, 5'd5} || ret_wr !== 2'b11 || rob_count !== 4'd2) begin n_bad++; $display("FAIL lui_jal_rd got rd=%h wr=%b cnt=%0d want 1/5 11 2", ret_rd, ret_wr, rob_count); end
        tick(); #1;
        n_cmp++; if (rob_empty !== 1'b1 || ret_valid !== 2'b00) begin n_bad++; $display("FAIL dual_drained got empty=%b rv=%b want 1/00", rob_empty, ret_valid); end
    endtask

    task automatic test_flush;
        do_reset();
        iss(BEQ, 5'd0, 32'h200, 32'h40, 0, 0); tick();
        iss(ADD, 5'd7, 32'h204, 32'h0, 0, 0); tick();
        idle(); cdb_valid = 2'b01; cdb_entry = {3'd0, 3'd1}; cdb_value = {32'd0, 32'h55};
        #1;
        n_cmp++; if (flush !== 1'b0) begin n_bad++; $display("FAIL br_pending_flush got %b want 0", flush); end
        tick();
        cdb_valid = 2'b01; cdb_entry = {3'd0, 3'd0}; cdb_value = {32'd0, 32'd1};
        #1;
        n_cmp++; if (ret_valid !== 2'b00) begin n_bad++; $display("FAIL br_pending_ret got %b want 00", ret_valid); end
        tick();
        idle(); rdy_in = 0;
        #1;
        n_cmp++; if (flush !== 1'b0 || ret_valid !== 2'b00 || flush_pc !== 32'd0) begin n_bad++; $display("FAIL frozen_gate got fl=%b rv=%b fpc=%h want 0/00/0", flush, ret_valid, flush_pc); end
        tick();
        rdy_in = 1;
        iss(ADD, 5'd9, 32'h300, 32'h0, 0, 0);
        #1;
        n_cmp++; if (flush !== 1'b1 || flush_pc !== 32'h240) begin n_bad++; $display("FAIL mispredict got fl=%b fpc=%h want 1/240", flush, flush_pc); end
        n_cmp++; if (ret_valid !== 2'b00 || rob_count !== 4'd2) begin n_bad++; $display("FAIL mispredict_hold got rv=%b cnt=%0d want 00/2", ret_valid, rob_count); end
        tick(); idle(); #1;
        n_cmp++; if (rob_empty !== 1'b1 || rob_count !== 4'd0 || issue_entry !== 3'd0 || flush !== 1'b0) begin n_bad++; $display("FAIL post_flush got empty=%b cnt=%0d tail=%0d fl=%b want 1/0/0/0", rob_empty, rob_count, issue_entry, flush); end
        iss(BEQ, 5'd0, 32'h300, 32'h8, 1, 0); tick();
        iss(LUI, 5'd2, 32'h304, 32'h1000, 0, 0);
        cdb_valid = 2'b01; cdb_entry = {3'd0, 3'd0}; cdb_value = {32'd0, 32'd1};
        tick(); idle(); #1;
        n_cmp++; if (flush !== 1'b0 || ret_valid !== 2'b01 || ret_wr !== 2'b00) begin n_bad++; $display("FAIL br_ok got fl=%b rv=%b wr=%b want 0/01/00", flush, ret_valid, ret_wr); end
        tick(); #1;
        n_cmp++; if (ret_valid !== 2'b01 || ret_entry[2:0] !== 3'd1 || ret_value[31:0] !== 32'h1000 || ret_wr !== 2'b01) begin n_bad++; $display("FAIL after_br got rv=%b ent=%0d val=%h wr=%b want 01/1/1000/01", ret_valid, ret_entry[2:0], ret_value[31:0], ret_wr); end
        tick();
        iss(BEQ, 5'd0, 32'h400, 32'h80, 1, 0); tick();
        idle(); cdb_valid = 2'b01; cdb_entry = {3'd0, 3'd2}; cdb_value = 64'd0;
        tick(); idle(); #1;
        n_cmp++; if (flush !== 1'b1 || flush_pc !== 32'h404) begin n_bad++; $display("FAIL nottaken_flush got fl=%b fpc=%h want 1/404", flush, flush_pc); end
        tick(); #1;
        n_cmp++; if (rob_empty !== 1'b1 || issue_entry !== 3'd0) begin n_bad++; $display("FAIL nottaken_clear got empty=%b tail=%0d want 1/0", rob_empty, issue_entry); end
    endtask

    task automatic test_wrap;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            iss(ADD, 5'(i + 1), 32'(4 * i), 32'h0, 0, 0);
            tick();
        end
        idle();
        for (int k = 0; k < 6; k++) begin
            int exp_cnt;
            if (k < 5) begin
                cdb_valid = 2'b01; cdb_entry = {3'd0, 3'(k)}; cdb_value = {32'd0, 32'(32'h100 + k)};
            end else begin
                cdb_valid = 2'b00;
            end
            exp_cnt = (k == 0) ? 8 : 9 - k;
            #1;
            n_cmp++; if (rob_count !== 4'(exp_cnt)) begin n_bad++; $display("FAIL drain_count_%0d got %0d want %0d", k, rob_count, exp_cnt); end
            if (k == 0) begin
                n_cmp++; if (ret_valid !== 2'b00) begin n_bad++; $display("FAIL drain_ret_0 got %b want 00", ret_valid); end
            end else begin
                n_cmp++; if (ret_valid !== 2'b01 || ret_entry[2:0] !== 3'(k - 1) || ret_value[31:0] !== 32'(32'h100 + k - 1)) begin n_bad++; $display("FAIL drain_ret_%0d got rv=%b ent=%0d val=%h want 01/%0d/%h", k, ret_valid, ret_entry[2:0], ret_value[31:0], k - 1, 32'h100 + k - 1); end
            end
            tick();
        end
        for (int j = 0; j < 5; j++) begin
            iss(ADD, 5'(20 + j), 32'(32'h80 + 4 * j), 32'h0, 0, 0);
            #1;
            n_cmp++; if (issue_entry !== 3'(j) || rob_count !== 4'(3 + j)) begin n_bad++; $display("FAIL refill_%0d got tail=%0d cnt=%0d want %0d/%0d", j, issue_entry, rob_count, j, 3 + j); end
            tick();
        end
        idle(); #1;
        n_cmp++; if (rob_full !== 1'b1 || rob_count !== 4'd8 || issue_entry !== 3'd5) begin n_bad++; $display("FAIL refill_full got full=%b cnt=%0d tail=%0d want 1/8/5", rob_full, rob_count, issue_entry); end
        cdb_valid = 2'b11; cdb_entry = {3'd6, 3'd5}; cdb_value = {32'h206, 32'h205};
        tick(); idle(); #1;
        n_cmp++; if (ret_valid !== 2'b11 || ret_entry !== {3'd6, 3'd5} || rob_count !== 4'd8) begin n_bad++; $display("FAIL wrap_ret56 got rv=%b ent=%b cnt=%0d want 11/110101/8", ret_valid, ret_entry, rob_count); end
        tick();
        cdb_valid = 2'b11; cdb_entry = {3'd0, 3'd7}; cdb_value = {32'h300, 32'h207};
        tick(); idle(); #1;
        n_cmp++; if (ret_valid !== 2'b11 || ret_entry !== {3'd0, 3'd7} || ret_value !== {32'h300, 32'h207} || rob_count !== 4'd6) begin n_bad++; $display("FAIL wrap_ret70 got rv=%b ent=%b val=%h cnt=%0d want 11/000111/300_207/6", ret_valid, ret_entry, ret_value, rob_count); end
        tick(); #1;
        n_cmp++; if (rob_count !== 4'd4 || issue_entry !== 3'd5 || rob_full !== 1'b0) begin n_bad++; $display("FAIL wrap_final got cnt=%0d tail=%0d full=%b want 4/5/0", rob_count, issue_entry, rob_full); end
    endtask

    task automatic test_reset_mid;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            iss(ADD, 5'(i + 1), 32'(4 * i), 32'h0, 0, 0);
            tick();
        end
        idle(); cdb_valid = 2'b01; cdb_entry = {3'd0, 3'd0}; cdb_value = {32'd0, 32'h11};
        tick(); idle(); #1;
        n_cmp++; if (ret_valid !== 2'b01 || rob_count !== 4'd4) begin n_bad++; $display("FAIL pre_reset got rv=%b cnt=%0d want 01/4", ret_valid, rob_count); end
        rst_n_in = 0;
        #1;
        n_cmp++; if (ret_valid !== 2'b00 || ret_value !== 64'd0 || ret_wr !== 2'b00 || ret_rd !== 10'd0 || ret_entry !== 6'd0) begin n_bad++; $display("FAIL async_ret got rv=%b val=%h want all 0", ret_valid, ret_value); end
        n_cmp++; if (rob_count !== 4'd0 || rob_empty !== 1'b1 || rob_full !== 1'b0 || flush !== 1'b0) begin n_bad++; $display("FAIL async_state got cnt=%0d empty=%b full=%b fl=%b want 0/1/0/0", rob_count, rob_empty, rob_full, flush); end
        tick();
        rst_n_in = 1;
        tick();
        n_cmp++; if (ret_valid !== 2'b00 || rob_empty !== 1'b1) begin n_bad++; $display("FAIL post_release got rv=%b empty=%b want 00/1", ret_valid, rob_empty); end
        iss(ADD, 5'd4, 32'h0, 32'h0, 0, 0);
        #1;
        n_cmp++; if (issue_entry !== 3'd0) begin n_bad++; $display("FAIL post_release_entry got %0d want 0", issue_entry); end
        tick(); idle(); #1;
        n_cmp++; if (rob_count !== 4'd1 || ret_valid !== 2'b00) begin n_bad++; $display("FAIL post_release_issue got cnt=%0d rv=%b want 1/00", rob_count, ret_valid); end
    endtask

    initial begin
        test_reset();
        test_full();
        test_cdb_collision();
        test_dual_retire();
        test_flush();
        test_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
